// File: rtl/shot_turn_controller_pkg.sv
// Shared types and helpers for the 5x5 battleship turn controller.
// Board cells are one bit each; a set bit marks an intact ship cell.
package battle_pkg;

    localparam int CELLS = 25;

    localparam logic TURN_PLAYER = 1'b0;
    localparam logic TURN_PC     = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_WAIT,
        S_P_APPLY,
        S_PC_PICK,
        S_PC_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    function automatic logic is_onehot25(input logic [CELLS-1:0] v);
        return (v != '0) && ((v & (v - CELLS'(1))) == '0);
    endfunction

endpackage

// File: rtl/shot_turn_controller_if.sv
// Match-control bundle between the input logic (master) and the controller (slave).
interface shot_turn_controller_if;
    import battle_pkg::*;

    logic             start;
    logic [CELLS-1:0] player_board_in;
    logic [CELLS-1:0] pc_board_in;
    logic             player_shot_valid;
    logic [CELLS-1:0] player_shot;

    logic [CELLS-1:0] player_board;
    logic [CELLS-1:0] pc_board;
    logic             turn;
    logic             shot_done;
    logic             shot_hit;
    logic             shot_invalid;
    logic             timeout;
    logic             game_over;
    logic             winner;

    modport master (
        output start, player_board_in, pc_board_in, player_shot_valid, player_shot,
        input  player_board, pc_board, turn, shot_done, shot_hit, shot_invalid,
               timeout, game_over, winner
    );

    modport slave (
        input  start, player_board_in, pc_board_in, player_shot_valid, player_shot,
        output player_board, pc_board, turn, shot_done, shot_hit, shot_invalid,
               timeout, game_over, winner
    );
endinterface

// File: rtl/shot_turn_controller_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, used for PC target picks.
module shot_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
        end
    end

    assign q = r_q;
endmodule

// File: rtl/shot_turn_controller.sv
// Battleship match sequencer: owns both boards, alternates turns, applies
// shots with clear-on-hit, enforces the player turn timeout and decides the winner.
module shot_turn_controller
    import battle_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 750_000_000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    shot_turn_controller_if.slave io_bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic [CELLS-1:0] r_player_board;
    logic [CELLS-1:0] r_pc_board;
    logic [CELLS-1:0] r_player_fired;
    logic [CELLS-1:0] r_pc_fired;
    logic [CELLS-1:0] r_shot_mask;
    logic [31:0]      r_cnt;
    logic             r_turn;
    logic             r_from_start;
    logic             r_shot_done;
    logic             r_shot_hit;
    logic             r_shot_invalid;
    logic             r_timeout;
    logic             r_game_over;
    logic             r_winner;

    logic [7:0]       w_lfsr_q;
    logic [2:0]       w_lfsr_unused;
    logic [4:0]       w_idx;
    logic [CELLS-1:0] w_idx_mask;
    logic             w_pick_ok;
    logic             w_shot_ok;
    logic             w_expired;

    shot_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state == S_PC_PICK),
        .seed (LFSR_SEED),
        .q    (w_lfsr_q)
    );

    assign {w_lfsr_unused, w_idx} = w_lfsr_q;
    // Indices 25..31 shift the bit out entirely, so an empty mask means "retry".
    assign w_idx_mask = CELLS'(1) << w_idx;
    assign w_pick_ok  = (w_idx_mask != '0) && ((w_idx_mask & r_pc_fired) == '0);
    assign w_shot_ok  = io_bus.player_shot_valid && is_onehot25(io_bus.player_shot)
                        && ((io_bus.player_shot & r_player_fired) == '0);
    assign w_expired  = (r_cnt == 32'(TURN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (io_bus.start) w_state_next = S_CHECK;
            S_P_WAIT: begin
                if (w_shot_ok)      w_state_next = S_P_APPLY;
                else if (w_expired) w_state_next = S_PC_PICK;
            end
            S_P_APPLY:  w_state_next = S_CHECK;
            S_PC_PICK:  if (w_pick_ok) w_state_next = S_PC_APPLY;
            S_PC_APPLY: w_state_next = S_CHECK;
            S_CHECK: begin
                if (r_pc_board == '0 || r_player_board == '0) w_state_next = S_DONE;
                else if (r_from_start || r_turn == TURN_PC)  w_state_next = S_P_WAIT;
                else                                         w_state_next = S_PC_PICK;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_player_board <= '0;
            r_pc_board     <= '0;
            r_player_fired <= '0;
            r_pc_fired     <= '0;
            r_shot_mask    <= '0;
            r_cnt          <= '0;
            r_turn         <= TURN_PLAYER;
            r_from_start   <= 1'b0;
            r_shot_done    <= 1'b0;
            r_shot_hit     <= 1'b0;
            r_shot_invalid <= 1'b0;
            r_timeout      <= 1'b0;
            r_game_over    <= 1'b0;
            r_winner       <= 1'b0;
        end else begin
            r_shot_done    <= 1'b0;
            r_shot_invalid <= 1'b0;
            r_timeout      <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_bus.start) begin
                        r_player_board <= io_bus.player_board_in;
                        r_pc_board     <= io_bus.pc_board_in;
                        r_player_fired <= '0;
                        r_pc_fired     <= '0;
                        r_turn         <= TURN_PLAYER;
                        r_from_start   <= 1'b1;
                        r_game_over    <= 1'b0;
                        r_winner       <= 1'b0;
                    end
                end
                S_P_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_shot_ok) begin
                        r_shot_mask <= io_bus.player_shot;
                    end else begin
                        r_shot_invalid <= io_bus.player_shot_valid;
                        if (w_expired) begin
                            r_timeout <= 1'b1;
                            r_turn    <= TURN_PC;
                        end
                    end
                end
                S_P_APPLY: begin
                    r_player_fired <= r_player_fired | r_shot_mask;
                    r_shot_hit     <= |(r_pc_board & r_shot_mask);
                    r_pc_board     <= r_pc_board & ~r_shot_mask;
                    r_shot_done    <= 1'b1;
                end
                S_PC_PICK: if (w_pick_ok) r_shot_mask <= w_idx_mask;
                S_PC_APPLY: begin
                    r_pc_fired     <= r_pc_fired | r_shot_mask;
                    r_shot_hit     <= |(r_player_board & r_shot_mask);
                    r_player_board <= r_player_board & ~r_shot_mask;
                    r_shot_done    <= 1'b1;
                end
                S_CHECK: begin
                    // A fresh match hands the first shot to the player instead of flipping.
                    r_from_start <= 1'b0;
                    if (r_pc_board == '0) begin
                        r_game_over <= 1'b1;
                        r_winner    <= 1'b0;
                    end else if (r_player_board == '0) begin
                        r_game_over <= 1'b1;
                        r_winner    <= 1'b1;
                    end else if (r_from_start || r_turn == TURN_PC) begin
                        r_turn <= TURN_PLAYER;
                        r_cnt  <= '0;
                    end else begin
                        r_turn <= TURN_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.player_board = r_player_board;
    assign io_bus.pc_board     = r_pc_board;
    assign io_bus.turn         = r_turn;
    assign io_bus.shot_done    = r_shot_done;
    assign io_bus.shot_hit     = r_shot_hit;
    assign io_bus.shot_invalid = r_shot_invalid;
    assign io_bus.timeout      = r_timeout;
    assign io_bus.game_over    = r_game_over;
    assign io_bus.winner       = r_winner;
endmodule

// File: tb/tb_shot_turn_controller.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_shot_turn_controller;
    localparam int EV_DONE = 0;
    localparam int EV_INV  = 1;
    localparam int EV_TO   = 2;
    localparam int EV_GO   = 3;
    localparam logic [24:0] ALL1 = 25'h1FF_FFFF;

    typedef struct {
        int          kind;
        logic        hit;
        logic        turn;
        logic        winner;
        logic [24:0] pc;
        int          pop;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    logic go_prev;
    exp_t sb[$];

    shot_turn_controller_if bus();

    shot_turn_controller #(.TURN_CYCLES(8), .LFSR_SEED(8'hA5)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic hit, input logic turn, input logic winner,
                        input logic [24:0] pc, input int pop);
        exp_t e;
        e.kind = kind; e.hit = hit; e.turn = turn; e.winner = winner; e.pc = pc; e.pop = pop;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual_kind=%0d required=no_event", kind);
            return;
        end
        e = sb.pop_front();
        $display("event kind=%0d turn=%0d hit=%0d win=%0d pc=%h pop=%0d", kind, bus.turn,
                 bus.shot_hit, bus.winner, bus.pc_board, $countones(bus.player_board));
        chk("ev_kind", 32'(kind), 32'(e.kind));
        chk("ev_turn", 32'(bus.turn), 32'(e.turn));
        chk("ev_pc_board", 32'(bus.pc_board), 32'(e.pc));
        chk("ev_player_pop", 32'($countones(bus.player_board)), 32'(e.pop));
        if (kind == EV_DONE) chk("ev_hit", 32'(bus.shot_hit), 32'(e.hit));
        if (kind == EV_GO)   chk("ev_winner", 32'(bus.winner), 32'(e.winner));
    endtask

    always @(negedge clk) begin
        if (bus.shot_done)                 check_evt(EV_DONE);
        if (bus.shot_invalid)              check_evt(EV_INV);
        if (bus.timeout)                   check_evt(EV_TO);
        if (bus.game_over && !go_prev)     check_evt(EV_GO);
        go_prev = bus.game_over;
    end

    task automatic do_start(input logic [24:0] pl, input logic [24:0] pc);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.player_board_in = pl; bus.pc_board_in = pc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic fire(input logic [24:0] shot);
        @(posedge clk); #1;
        bus.player_shot_valid = 1'b1; bus.player_shot = shot;
        @(posedge clk); #1;
        bus.player_shot_valid = 1'b0;
    endtask

    task automatic wait_pc_done(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.shot_done && bus.turn) return;
        end
        checks++;
        failures++;
        $display("FAIL %s actual=no_pc_shot required=pc_shot_done", name);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_outputs"}, {25'd0, bus.turn, bus.shot_done, bus.shot_hit, bus.shot_invalid,
             bus.timeout, bus.game_over, bus.winner}, 32'd0);
        chk({name, "_boards"}, 32'(bus.player_board | bus.pc_board), 32'd0);
    endtask

    initial begin
        int c0;
        int seen;
        checks = 0; failures = 0; cyc = 0; go_prev = 1'b0;
        bus.start = 1'b0; bus.player_board_in = '0; bus.pc_board_in = '0;
        bus.player_shot_valid = 1'b0; bus.player_shot = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Reset lands while the player's shot is in P_APPLY: nothing may leak out.
        do_start(ALL1, 25'h13);
        @(posedge clk); #1;
        bus.player_shot_valid = 1'b1; bus.player_shot = 25'h2;
        @(posedge clk); #1;
        bus.player_shot_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_mid_apply");

        // Invalid shots, hit, repeat, timeout, miss, winning shot.
        do_start(ALL1, 25'h11);
        push(EV_INV, 1'b0, 1'b0, 1'b0, 25'h11, 25);
        fire(25'h3);
        push(EV_INV, 1'b0, 1'b0, 1'b0, 25'h11, 25);
        fire(25'h0);
        @(negedge clk);
        chk("invalid_pc_board", 32'(bus.pc_board), 32'h11);
        chk("invalid_turn", 32'(bus.turn), 32'd0);
        push(EV_DONE, 1'b1, 1'b0, 1'b0, 25'h01, 25);
        push(EV_DONE, 1'b1, 1'b1, 1'b0, 25'h01, 24);
        fire(25'h10);
        wait_pc_done("wait_pc1");

        push(EV_INV, 1'b0, 1'b0, 1'b0, 25'h01, 24);
        push(EV_TO,  1'b0, 1'b1, 1'b0, 25'h01, 24);
        push(EV_DONE, 1'b1, 1'b1, 1'b0, 25'h01, 23);
        @(posedge clk); #1;
        c0 = cyc;
        bus.player_shot_valid = 1'b1; bus.player_shot = 25'h10;
        @(posedge clk); #1;
        bus.player_shot_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.timeout) seen = 1;
        end
        chk("timeout_cycle", 32'(cyc - c0), 32'd8);
        wait_pc_done("wait_pc2");

        push(EV_DONE, 1'b0, 1'b0, 1'b0, 25'h01, 23);
        push(EV_DONE, 1'b1, 1'b1, 1'b0, 25'h01, 22);
        fire(25'h8);
        wait_pc_done("wait_pc3");

        push(EV_DONE, 1'b1, 1'b0, 1'b0, 25'h00, 22);
        push(EV_GO,   1'b0, 1'b0, 1'b0, 25'h00, 22);
        fire(25'h1);
        repeat (4) @(posedge clk);

        // Restart from DONE with an empty player board: PC wins without a shot.
        push(EV_GO, 1'b0, 1'b0, 1'b1, 25'h0F, 0);
        do_start(25'h0, 25'h0F);
        repeat (4) @(posedge clk);

        // Single-cell PC fleet sunk by the first player shot.
        push(EV_DONE, 1'b1, 1'b0, 1'b0, 25'h00, 25);
        push(EV_GO,   1'b0, 1'b0, 1'b0, 25'h00, 25);
        do_start(ALL1, 25'h1);
        fire(25'h1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_game_over", 32'(bus.game_over), 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
